// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer and the ALU decoder.
package muldiv_pkg;

  localparam int unsigned CNTW = 5;

  typedef enum logic [1:0] {
    OpMul   = 2'b00,
    OpMulhu = 2'b01,
    OpDivu  = 2'b10,
    OpRemu  = 2'b11
  } muldivOpE;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StRun  = 2'b10,
    StDone = 2'b11
  } muldivStateE;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, built around the borrowed ALU.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            isDiv,
  input  logic [XLEN-1:0] hi,        // P_hi or remainder
  input  logic [XLEN-1:0] lo,        // P_lo or quotient
  input  logic [XLEN-1:0] operand,   // multiplicand or divisor
  input  logic [XLEN-1:0] aluResult,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [2:0]      aluCtrl,
  output logic [XLEN-1:0] hiNext,
  output logic [XLEN-1:0] loNext
);

  logic [XLEN-1:0] shifted;
  logic            carry;
  logic            take;

  assign shifted = {hi[XLEN-2:0], lo[XLEN-1]};
  // The ALU add drops the carry; recover it from unsigned wrap-around.
  assign carry   = (aluResult < hi);
  // A set top remainder bit means the 33-bit partial value always exceeds the divisor.
  assign take    = hi[XLEN-1] | (shifted >= operand);

  always_comb begin
    srcA    = '0;
    srcB    = '0;
    aluCtrl = ALU_ADD;
    hiNext  = hi;
    loNext  = lo;
    if (isDiv) begin
      srcA    = shifted;
      srcB    = operand;
      aluCtrl = ALU_SUB;
      hiNext  = take ? aluResult : shifted;
      loNext  = {lo[XLEN-2:0], take};
    end else begin
      srcA    = hi;
      srcB    = lo[0] ? operand : '0;
      aluCtrl = ALU_ADD;
      hiNext  = {carry, aluResult[XLEN-1:1]};
      loNext  = {aluResult[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU controller that borrows the shared execute-stage ALU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [1:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            ReqM,
  input  logic            GrantM,
  output logic [XLEN-1:0] SrcAM,
  output logic [XLEN-1:0] SrcBM,
  output logic [2:0]      ALUControlM,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE
);

  muldivStateE     stateQ, stateD;
  logic [1:0]      opQ, opD;
  logic [XLEN-1:0] hiQ, hiD;
  logic [XLEN-1:0] loQ, loD;
  logic [XLEN-1:0] operandQ, operandD;
  logic [CNTW-1:0] cntQ, cntD;
  logic [XLEN-1:0] resultQ, resultD;

  logic [XLEN-1:0] stepSrcA, stepSrcB, stepHi, stepLo, resultSel;
  logic [2:0]      stepCtrl;

  muldiv_step #(
    .XLEN(XLEN)
  ) uStep (
    .isDiv    (opQ[1]),
    .hi       (hiQ),
    .lo       (loQ),
    .operand  (operandQ),
    .aluResult(ALUResultM),
    .srcA     (stepSrcA),
    .srcB     (stepSrcB),
    .aluCtrl  (stepCtrl),
    .hiNext   (stepHi),
    .loNext   (stepLo)
  );

  // MULHU/REMU live in the high register, MUL/DIVU in the low one.
  assign resultSel = opQ[0] ? hiQ : loQ;

  always_comb begin
    stateD   = stateQ;
    opD      = opQ;
    hiD      = hiQ;
    loD      = loQ;
    operandD = operandQ;
    cntD     = cntQ;
    resultD  = resultQ;
    ReqM     = 1'b0;
    BusyE    = 1'b0;
    DoneE    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (StartE) begin
          BusyE = 1'b1;
          opD   = OpE;
          cntD  = '0;
          if (OpE[1] && (SrcBE == '0)) begin
            // Divide by zero: preload quotient all-ones and remainder = dividend.
            hiD      = SrcAE;
            loD      = '1;
            operandD = '0;
            stateD   = StDone;
          end else begin
            hiD      = '0;
            loD      = OpE[1] ? SrcAE : SrcBE;
            operandD = OpE[1] ? SrcBE : SrcAE;
            stateD   = StReq;
          end
        end
      end
      StReq, StRun: begin
        ReqM  = 1'b1;
        BusyE = 1'b1;
        if (GrantM) begin
          hiD  = stepHi;
          loD  = stepLo;
          cntD = cntQ + CNTW'(1);
          if (cntQ == '1) begin
            stateD = StDone;
          end else begin
            stateD = StRun;
          end
        end
      end
      StDone: begin
        DoneE   = 1'b1;
        resultD = resultSel;
        stateD  = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  assign ResultE     = (stateQ == StDone) ? resultSel : resultQ;
  assign SrcAM       = ReqM ? stepSrcA : '0;
  assign SrcBM       = ReqM ? stepSrcB : '0;
  assign ALUControlM = ReqM ? stepCtrl : 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      opQ      <= '0;
      hiQ      <= '0;
      loQ      <= '0;
      operandQ <= '0;
      cntQ     <= '0;
      resultQ  <= '0;
    end else begin
      stateQ   <= stateD;
      opQ      <= opD;
      hiQ      <= hiD;
      loQ      <= loD;
      operandQ <= operandD;
      cntQ     <= cntD;
      resultQ  <= resultD;
    end
  end

endmodule
